// File: rtl/fc_reg_reader.sv
// Read-side sequencer for the FC layer register file.
// Sweeps a contiguous, wrapping address window of the register file and streams
// each (data, pos, addr) tuple on a valid/ready port. It pulses done_o once the
// final beat has been accepted.
module fc_reg_reader #(
   parameter int DATA_W = 32,
   parameter int POS_W  = 4,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   count_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] op_address_o,
   input  logic [DATA_W-1:0] reg_i,
   input  logic [POS_W-1:0]  pos_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic [POS_W-1:0]  m_pos_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic              m_last_o
);

   // state    | meaning
   // ST_IDLE  | waiting for start_i; zero-length requests answered with done
   // ST_FETCH | capturing one register-file entry per free output slot
   // ST_DRAIN | last beat captured, waiting for it to be accepted
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_C       = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic [ADDR_W-1:0]   op_address_q, op_address_d;
   logic                done_q, done_d;
   logic                m_valid_q, m_valid_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
   logic [POS_W-1:0]    m_pos_q, m_pos_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic                m_last_q, m_last_d;

   logic [ADDR_W:0]     cnt_clamped;
   logic                slot_free;

   // Requests longer than the register file still visit each entry only once.
   assign cnt_clamped = (count_i > DEPTH_C) ? DEPTH_C : count_i;
   assign slot_free   = !m_valid_q || m_ready_i;

   // Next-state and datapath decisions; every register holds unless told otherwise.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      op_address_d = op_address_q;
      done_d       = 1'b0;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_pos_d      = m_pos_q;
      m_addr_d     = m_addr_q;
      m_last_d     = m_last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (cnt_clamped == '0) begin
                  done_d = 1'b1;
               end else begin
                  op_address_d = base_addr_i;
                  remaining_d  = cnt_clamped;
                  state_d      = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            if (slot_free) begin
               m_valid_d    = 1'b1;
               m_data_d     = reg_i;
               m_pos_d      = pos_i;
               m_addr_d     = op_address_q;
               m_last_d     = (remaining_q == ONE_C);
               remaining_d  = remaining_q - ONE_C;
               op_address_d = (op_address_q == LAST_ADDR_C) ? '0 : op_address_q + 1'b1;
               if (remaining_q == ONE_C) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (m_valid_q && m_ready_i) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything, including an in-flight sweep.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         op_address_q <= '0;
         done_q       <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_pos_q      <= '0;
         m_addr_q     <= '0;
         m_last_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         op_address_q <= op_address_d;
         done_q       <= done_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_pos_q      <= m_pos_d;
         m_addr_q     <= m_addr_d;
         m_last_q     <= m_last_d;
      end
   end

   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = done_q;
   assign op_address_o = op_address_q;
   assign m_valid_o    = m_valid_q;
   assign m_data_o     = m_data_q;
   assign m_pos_o      = m_pos_q;
   assign m_addr_o     = m_addr_q;
   assign m_last_o     = m_last_q;

endmodule

// File: tb/tb_fc_reg_reader.sv
// Bench for fc_reg_reader: a register-file model plus a window/beat reference model.
module tb_fc_reg_reader;

   logic        clk_i = 1'b0;
   logic        reset_n;
   logic        start_i;
   logic [4:0]  base_addr_i;
   logic [5:0]  count_i;
   logic        busy_o;
   logic        done_o;
   logic [4:0]  op_address_o;
   logic [31:0] reg_i;
   logic [3:0]  pos_i;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [31:0] m_data_o;
   logic [3:0]  m_pos_o;
   logic [4:0]  m_addr_o;
   logic        m_last_o;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  pos;
      logic        last;
   } beat_t;

   logic [31:0] rf_data [32];
   logic [3:0]  rf_pos  [32];

   beat_t obs_q[$];
   beat_t exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt, done_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc, stab_err;
   bit busy_seen, valid_seen, hold_prev;
   beat_t held;

   fc_reg_reader dut (
      .clk_i        (clk_i),
      .reset_n      (reset_n),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .count_i      (count_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .op_address_o (op_address_o),
      .reg_i        (reg_i),
      .pos_i        (pos_i),
      .m_valid_o    (m_valid_o),
      .m_ready_i    (m_ready_i),
      .m_data_o     (m_data_o),
      .m_pos_o      (m_pos_o),
      .m_addr_o     (m_addr_o),
      .m_last_o     (m_last_o)
   );

   assign reg_i = rf_data[op_address_o];
   assign pos_i = rf_pos[op_address_o];

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   // Observer on the falling edge: records beats that will transfer at the next rise.
   always @(negedge clk_i) begin
      if (!reset_n) begin
         hold_prev = 1'b0;
      end else begin
         if (busy_o) busy_seen = 1'b1;
         if (m_valid_o) begin
            valid_seen = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (hold_prev && (!m_valid_o || {m_addr_o, m_data_o, m_pos_o, m_last_o} !== held))
            stab_err++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (m_valid_o && m_ready_i) begin
            obs_q.push_back({m_addr_o, m_data_o, m_pos_o, m_last_o});
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
         end
         hold_prev = m_valid_o && !m_ready_i;
         held      = {m_addr_o, m_data_o, m_pos_o, m_last_o};
      end
   end

   task automatic fill_rf();
      for (int i = 0; i < 32; i++) begin
         rf_data[i] = $urandom;
         rf_pos[i]  = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic clear_obs();
      obs_q.delete();
      done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
      first_acc_cyc = -1; last_acc_cyc = -1; stab_err = 0;
      busy_seen = 1'b0; valid_seen = 1'b0;
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: random ready.
   // inject_at >= 0 pulses a stray start (base 7, count 3) at that cycle of the sweep.
   task automatic run_sweep(input string name, input int base, input int count,
                            input int mode, input int inject_at);
      int    n;
      int    start_cyc;
      beat_t e;
      n = (count > 32) ? 32 : count;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         e.addr = 5'((base + i) % 32);
         e.data = rf_data[(base + i) % 32];
         e.pos  = rf_pos[(base + i) % 32];
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
      clear_obs();
      @(posedge clk_i); #1;
      start_i     = 1'b1;
      base_addr_i = 5'(base);
      count_i     = 6'(count);
      m_ready_i   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      start_cyc   = cyc;
      for (int k = 0; k < 400 && done_cnt == 0; k++) begin
         @(posedge clk_i); #1;
         start_i = (k == inject_at);
         if (k == inject_at) begin
            base_addr_i = 5'd7;
            count_i     = 6'd3;
         end
         case (mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = (k % 2 == 1);
            default: m_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
      start_i = 1'b0;
      repeat (4) begin
         @(posedge clk_i); #1;
         m_ready_i = 1'($urandom_range(0, 1));
      end

      n_cmp++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
      end
      n_cmp++;
      if (obs_q.size() !== n) begin
         n_fail++;
         $display("FAIL %s beat_count: got %0d want %0d", name, obs_q.size(), n);
      end
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s beat[%0d]: got addr=%0d data=%h pos=%h last=%b want addr=%0d data=%h pos=%h last=%b",
                     name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].pos, obs_q[i].last,
                     exp_q[i].addr, exp_q[i].data, exp_q[i].pos, exp_q[i].last);
         end
      end
      n_cmp++;
      if (stab_err !== 0) begin
         n_fail++;
         $display("FAIL %s stall_stability: got %0d violations want 0", name, stab_err);
      end
      if (n > 0) begin
         n_cmp++;
         if (first_valid_cyc !== start_cyc + 2) begin
            n_fail++;
            $display("FAIL %s first_valid_latency: got %0d want %0d", name,
                     first_valid_cyc - start_cyc, 2);
         end
         n_cmp++;
         if (done_cyc !== last_acc_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_acc_cyc + 1);
         end
         if (mode == 0) begin
            n_cmp++;
            if (last_acc_cyc - first_acc_cyc !== n - 1) begin
               n_fail++;
               $display("FAIL %s no_bubbles: got span %0d want %0d", name,
                        last_acc_cyc - first_acc_cyc, n - 1);
            end
         end
      end else begin
         n_cmp++;
         if (done_cyc !== start_cyc + 1) begin
            n_fail++;
            $display("FAIL %s zero_done_timing: got cycle %0d want %0d", name, done_cyc, start_cyc + 1);
         end
         n_cmp++;
         if (valid_seen || busy_seen) begin
            n_fail++;
            $display("FAIL %s zero_quiet: got valid=%b busy=%b want 0 0", name, valid_seen, busy_seen);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0; m_ready_i = 1'b0;
      fill_rf();
      clear_obs();
      repeat (3) @(posedge clk_i);
      #1;
      n_cmp++;
      if ({busy_o, done_o, op_address_o, m_valid_o, m_data_o, m_pos_o, m_addr_o, m_last_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b addr=%0d valid=%b want all 0",
                  busy_o, done_o, op_address_o, m_valid_o);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         rf_data[i] = 32'h10 + i;
      end
      run_sweep("back_to_back", 0, 4, 0, -1);
   endtask

   task automatic test_ready_toggle();
      run_sweep("ready_toggle", 0, 4, 1, -1);
   endtask

   task automatic test_wrap();
      fill_rf();
      run_sweep("wrap", 30, 4, 0, -1);
   endtask

   task automatic test_zero_count();
      run_sweep("zero_count", 5, 0, 0, -1);
   endtask

   task automatic test_start_ignored();
      fill_rf();
      run_sweep("start_ignored", 12, 6, 2, 2);
   endtask

   task automatic test_clamp();
      fill_rf();
      run_sweep("clamp_40", 3, 40, 0, -1);
      run_sweep("after_clamp_1", 9, 1, 0, -1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         fill_rf();
         run_sweep("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 2)), -1);
      end
   endtask

   task automatic test_abort();
      int k;
      fill_rf();
      clear_obs();
      @(posedge clk_i); #1;
      start_i = 1'b1; base_addr_i = 5'd4; count_i = 6'd10; m_ready_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      k = 0;
      while (obs_q.size() < 2 && k < 50) begin
         @(posedge clk_i); #1;
         k++;
      end
      n_cmp++;
      if (obs_q.size() < 2) begin
         n_fail++;
         $display("FAIL abort_progress: got %0d beats want >=2", obs_q.size());
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy_o, done_o, op_address_o, m_valid_o, m_data_o, m_pos_o, m_addr_o, m_last_o} !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: got busy=%b valid=%b data=%h addr=%0d want all 0",
                  busy_o, m_valid_o, m_data_o, m_addr_o);
      end
      repeat (2) @(posedge clk_i);
      #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      n_cmp++;
      if (done_cnt !== 0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: got done_count=%0d busy=%b want 0 0", done_cnt, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_ready_toggle();
      test_wrap();
      test_zero_count();
      test_start_ignored();
      test_clamp();
      test_random();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
